axi_downsizer_2to1: RTL and testbench

AXI_DOWNSIZER_2TO1 -- requirements
Module: axi_downsizer_2to1

---
 rtl/axi_m2_pkg.sv | 10 +
 rtl/axi_downsizer_2to1.sv | 88 ++++++++
 tb/tb_axi_downsizer_2to1.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_m2_pkg.sv
// Shared state encodings for the 2:1 AXI-Stream downsizer.
package axi_m2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

endpackage

// File: rtl/axi_downsizer_2to1.sv
// Splits each 2*DATA_WIDTH input beat into two DATA_WIDTH output beats.
// Define AXI_DOWNSIZE_HIGH_FIRST_EN to emit the high half first.
module axi_downsizer_2to1
  import axi_m2_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic                    s_axis_tvalid,
  input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] held;
  logic                    held_last;
  logic                    in_hs;
  logic                    out_hs;
  logic [DATA_WIDTH-1:0]   first_half;
  logic [DATA_WIDTH-1:0]   second_half;

  assign s_axis_tready = (state == IDLE) | ((state == SECOND) & m_axis_tready);
  assign m_axis_tvalid = (state != IDLE);
  assign in_hs         = s_axis_tvalid & s_axis_tready;
  assign out_hs        = m_axis_tvalid & m_axis_tready;

`ifdef AXI_DOWNSIZE_HIGH_FIRST_EN
  assign first_half  = held[2*DATA_WIDTH-1:DATA_WIDTH];
  assign second_half = held[DATA_WIDTH-1:0];
`else
  assign first_half  = held[DATA_WIDTH-1:0];
  assign second_half = held[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state     <= IDLE;
      held      <= '0;
      held_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            held      <= s_axis_tdata;
            held_last <= s_axis_tlast;
            state     <= FIRST;
          end
        end
        FIRST: begin
          if (out_hs) state <= SECOND;
        end
        SECOND: begin
          // A new beat may be loaded on the same edge the second half leaves.
          if (out_hs) begin
            if (in_hs) begin
              held      <= s_axis_tdata;
              held_last <= s_axis_tlast;
              state     <= FIRST;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tlast = 1'b0;
    case (state)
      FIRST:   m_axis_tdata = first_half;
      SECOND: begin
        m_axis_tdata = second_half;
        m_axis_tlast = held_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_downsizer_2to1.sv
// Scoreboard bench for axi_downsizer_2to1 (DATA_WIDTH=16); honours AXI_DOWNSIZE_HIGH_FIRST_EN.
module tb_axi_downsizer_2to1;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          sync_reset = 1'b1;
  logic          s_valid = 1'b0;
  logic [2*DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;

  logic          ready_val = 1'b0;
  logic          ready_rand = 1'b0;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  int            in_lasts = 0;
  int            out_lasts = 0;
  logic [DW:0]   exp_q[$];
  int            out_cyc[$];
  int            acc_cyc;

  axi_downsizer_2to1 #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .s_axis_tvalid(s_valid),
    .s_axis_tdata (s_data),
    .s_axis_tlast (s_last),
    .s_axis_tready(s_ready),
    .m_axis_tvalid(m_valid),
    .m_axis_tdata (m_data),
    .m_axis_tlast (m_last),
    .m_axis_tready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output handshake pops one expected half.
  always @(negedge clk) begin
    if (!sync_reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h last %0d expected nothing at cycle %0d", m_data, m_last, cyc);
      end else begin
        chk("out_half", {15'd0, m_last, m_data}, {15'd0, exp_q.pop_front()});
      end
      out_cyc.push_back(cyc);
      if (m_last) out_lasts++;
    end
  end

  task automatic send_beat(input logic [2*DW-1:0] d, input logic l);
    bit done = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_ready) begin
`ifdef AXI_DOWNSIZE_HIGH_FIRST_EN
        exp_q.push_back({1'b0, d[2*DW-1:DW]});
        exp_q.push_back({l, d[DW-1:0]});
`else
        exp_q.push_back({1'b0, d[DW-1:0]});
        exp_q.push_back({l, d[2*DW-1:DW]});
`endif
        if (l) in_lasts++;
        acc_cyc = cyc;
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1;
    end
    chk("drain", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  int n0;
  int acc[8];

  initial begin
    repeat (3) @(posedge clk);
    #1 sync_reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {16'd0, m_data}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    @(posedge clk); #1;

    // Single beat, ready high: 0x1234 then 0xBEEF on consecutive cycles.
    ready_val = 1'b1;
    @(posedge clk); #1;
    n0 = out_cyc.size();
    send_beat(32'hBEEF_1234, 1'b1);
    wait_drain();
    chk("single_count", out_cyc.size() - n0, 32'd2);
    if (out_cyc.size() == n0 + 2) chk("single_consec", out_cyc[n0+1] - out_cyc[n0], 32'd1);

    // Eight back-to-back beats.
    n0 = out_cyc.size();
    for (int i = 0; i < 8; i++) begin
      send_beat({16'hA000 + 16'(i), 16'h5000 + 16'(i)}, i == 7);
      acc[i] = acc_cyc;
    end
    for (int i = 1; i < 8; i++) chk("b2b_accept_gap", acc[i] - acc[i-1], 32'd2);
    wait_drain();
    chk("b2b_count", out_cyc.size() - n0, 32'd16);
    if (out_cyc.size() == n0 + 16) chk("b2b_consec", out_cyc[n0+15] - out_cyc[n0], 32'd15);

    // Stall for 5 cycles while the second half is presented.
    ready_val = 1'b0;
    @(posedge clk); #1;
    send_beat(32'hBEEF_1234, 1'b1);
    ready_val = 1'b1;
    @(posedge clk); #1;
    ready_val = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hAAAA_5555;
    s_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
`ifdef AXI_DOWNSIZE_HIGH_FIRST_EN
      chk("stall_data", {16'd0, m_data}, 32'h1234);
`else
      chk("stall_data", {16'd0, m_data}, 32'hBEEF);
`endif
      chk("stall_last", {31'd0, m_last}, 32'd1);
      chk("stall_valid", {31'd0, m_valid}, 32'd1);
      chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    ready_val = 1'b1;
    wait_drain();
    send_beat(32'hAAAA_5555, 1'b0);
    wait_drain();

    // Reset while the first half is pending; valid held high through reset.
    ready_val = 1'b0;
    @(posedge clk); #1;
    send_beat(32'hBEEF_1234, 1'b1);
    in_lasts--;
    sync_reset = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_C0DE;
    s_last  = 1'b1;
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    sync_reset = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    n0 = out_cyc.size();
    ready_val = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("post_rst_no_out", out_cyc.size() - n0, 32'd0);

    // Random valid gaps and random ready, 1000 beats.
    in_lasts = 0;
    out_lasts = 0;
    ready_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_beat($urandom, $urandom_range(0, 3) == 0);
    end
    wait_drain();
    chk("tlast_count", out_lasts, in_lasts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
